uart_tx_feeder: RTL and testbench

Byte buffer and flow controller sitting directly upstream of the UART `transmitter`. It accepts bytes from a host over a valid/ready write port and stores them in a DEPTH-entry FIFO. It presents them one at a time on the transmitter's `i_enable` / `i_tx_byte` inputs, and uses the transmitter's `o_tx_done` to pace the next byte with a programmable idle gap.

---
 rtl/uart_tx_feeder.sv | 145 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_feeder
// Purpose : FIFO byte buffer that feeds a UART transmitter one byte at a time.
//           After each transmitter done edge it holds a fixed idle gap before
//           presenting the next byte.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_wr_valid,
  input  logic [7:0]               i_wr_data,
  output logic                     o_wr_ready,
  output logic                     o_tx_enable,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_done,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] C_GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_done_rise;

  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == C_DEPTH);
  assign o_wr_ready  = ~o_full;
  assign o_count     = count_q;
  assign o_tx_enable = tx_en_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_overflow  = ovf_q;

  // A done level held high must not retrigger, so only the rising edge counts.
  assign w_done_rise = i_tx_done & ~done_q;
  assign w_push      = i_wr_valid & ~o_full;
  assign w_pop       = (state_q == S_IDLE) & ~o_empty;

  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    tx_byte_d = tx_byte_q;
    gap_d     = gap_q;
    ovf_d     = ovf_q | (i_wr_valid & o_full);
    wr_ptr_d  = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          tx_byte_d = mem_q[rd_ptr_q];
          tx_en_d   = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (w_done_rise) begin
          tx_en_d = 1'b0;
          gap_d   = C_GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      gap_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_en_q   <= tx_en_d;
      tx_byte_q <= tx_byte_d;
      gap_q     <= gap_d;
      done_q    <= i_tx_done;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_feeder
// Purpose : Directed self-checking bench for uart_tx_feeder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       tx_done  = 1'b0;
  logic       wr_ready, tx_enable, empty, full, busy, overflow;
  logic [7:0] tx_byte;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_tx_enable(tx_enable),
    .o_tx_byte  (tx_byte),
    .i_tx_done  (tx_done),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_busy     (busy),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Byte is in flight now; hold it, pulse done, then verify the idle gap.
  task automatic xfer(input logic [7:0] exp, input int hold);
    chk("xfer_en", tx_enable, 1'b1);
    chk("xfer_byte", tx_byte, exp);
    repeat (hold) tick();
    chk("xfer_hold_en", tx_enable, 1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done_en_low", tx_enable, 1'b0);
    chk("done_busy", busy, 1'b1);
    for (int i = 1; i <= GAP; i++) begin
      tick();
      chk("gap_en_low", tx_enable, 1'b0);
      chk("gap_busy", busy, (i < GAP) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", tx_enable, 1'b0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single byte, done 20 clocks after enable
    push(8'hAB);
    chk("t1_count1", count, 5'd1);
    chk("t1_en_early", tx_enable, 1'b0);
    tick();
    chk("t1_count0", count, 5'd0);
    xfer(8'hAB, 19);
    chk("t1_count_end", count, 5'd0);
    chk("t1_byte_kept", tx_byte, 8'hAB);
    chk("t1_empty", empty, 1'b1);

    // Burst of three: second push coincides with the first pop
    push(8'h11);
    chk("t2_count_a", count, 5'd1);
    push(8'h22);
    chk("t2_count_b", count, 5'd1);
    push(8'h33);
    chk("t2_count_c", count, 5'd2);
    xfer(8'h11, 3);
    tick();
    chk("t2_count_d", count, 5'd1);
    xfer(8'h22, 3);
    tick();
    chk("t2_count_e", count, 5'd0);
    xfer(8'h33, 3);

    // Done held high across two transfers must not retrigger
    push(8'h44);
    push(8'h55);
    chk("t3_byte44", tx_byte, 8'h44);
    chk("t3_count", count, 5'd1);
    tx_done = 1'b1;
    tick();
    chk("t3_first_done", tx_enable, 1'b0);
    repeat (GAP + 1) tick();
    chk("t3_en55", tx_enable, 1'b1);
    chk("t3_byte55", tx_byte, 8'h55);
    repeat (10) tick();
    chk("t3_held_no_retrig", tx_enable, 1'b1);
    tx_done = 1'b0;
    tick();
    chk("t3_fall_no_done", tx_enable, 1'b1);
    xfer(8'h55, 0);

    // Fill while stalled in SEND, overflow, then drain through pointer wrap
    push(8'hA0);
    for (int i = 0; i < DEPTH; i++) push(8'hB0 + 8'(i));
    chk("t4_count16", count, 5'd16);
    chk("t4_full", full, 1'b1);
    chk("t4_ready", wr_ready, 1'b0);
    chk("t4_ovf_pre", overflow, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tick();
    wr_valid = 1'b0;
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_count_kept", count, 5'd16);
    xfer(8'hA0, 2);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("t4_drain_count", count, 5'(15 - i));
      xfer(8'hB0 + 8'(i), 1);
    end
    chk("t4_empty", empty, 1'b1);
    chk("t4_ovf_sticky", overflow, 1'b1);

    // Simultaneous push and pop in IDLE with two queued
    push(8'hC0);
    push(8'hC1);
    push(8'hC2);
    chk("t5_count2", count, 5'd2);
    xfer(8'hC0, 2);
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    tick();
    wr_valid = 1'b0;
    chk("t5_count_same", count, 5'd2);
    chk("t5_en", tx_enable, 1'b1);
    chk("t5_oldest", tx_byte, 8'hC1);

    // Asynchronous reset mid-SEND with five queued
    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    chk("t6_count5", count, 5'd5);
    chk("t6_en", tx_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_en", tx_enable, 1'b0);
    chk("t6_count", count, 5'd0);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_busy", busy, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_enable", tx_enable, 1'b0);
    end
    chk("t6_count_after", count, 5'd0);
    chk("t6_empty_after", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
